// File: rtl/vga_pkg.sv
// Shared VGA raster defaults and RGB444 field layout.
// Imported by the timing core, the colour stage and any later overlay stages.
package vga_pkg;

  localparam int unsigned CLK_DIV_DEF  = 2;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned SEP_W_DEF    = 4;

  localparam int unsigned CH_W      = 4;
  localparam int unsigned RGB_W     = 3 * CH_W;
  localparam int unsigned RED_LSB   = 8;
  localparam int unsigned GREEN_LSB = 4;
  localparam int unsigned BLUE_LSB  = 0;
  localparam int unsigned CODE_W    = 2 * RGB_W;
  localparam int unsigned TENS_LSB  = RGB_W;
  localparam int unsigned ONES_LSB  = 0;

  typedef logic [RGB_W-1:0] rgb444_t;

  function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width that stays legal for a modulus of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, horizontal/vertical raster counters and raw sync/active decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned HCNT_W   = cnt_width(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int unsigned VCNT_W   = cnt_width(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic              clk,
  input  logic              rst,
  output logic              pix_en,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt,
  output logic              hs_raw,
  output logic              vs_raw,
  output logic              active
);

  localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = cnt_width(CLK_DIV);

  localparam logic [DIV_W-1:0]  DivLast  = DIV_W'(CLK_DIV - 1);
  localparam logic [HCNT_W-1:0] HLast    = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] HActEnd  = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] HSyncLo  = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] HSyncHi  = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_W-1:0] VLast    = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] VActEnd  = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] VSyncLo  = VCNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W-1:0] VSyncHi  = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic              h_last, v_last;

  // With CLK_DIV=1 DivLast is 0, so the divider never leaves 0 and pix_en stays high.
  assign pix_en = (div_q == DivLast);
  assign h_last = (hcnt_q == HLast);
  assign v_last = (vcnt_q == VLast);

  always_comb begin
    div_d  = pix_en ? '0 : div_q + DIV_W'(1);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      hcnt_d = h_last ? '0 : hcnt_q + HCNT_W'(1);
      if (h_last) begin
        vcnt_d = v_last ? '0 : vcnt_q + VCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign hs_raw = !((hcnt_q >= HSyncLo) && (hcnt_q < HSyncHi));
  assign vs_raw = !((vcnt_q >= VSyncLo) && (vcnt_q < VSyncHi));
  assign active = (hcnt_q < HActEnd) && (vcnt_q < VActEnd);

endmodule

// File: rtl/vga_color_split.sv
// Paints the tens colour on the left half and the ones colour on the right half of a VGA
// raster, with a black separator column; the code is sampled once per frame.
module vga_color_split
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned SEP_W    = SEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  output logic              hsync,
  output logic              vsync,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              frame_tick
);

  localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HCNT_W  = cnt_width(H_TOTAL);
  localparam int unsigned VCNT_W  = cnt_width(V_TOTAL);

  localparam logic [HCNT_W-1:0] HLast = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] VLast = VCNT_W'(V_TOTAL - 1);
  localparam logic [HCNT_W-1:0] HHalf = HCNT_W'(H_ACTIVE / 2);
  // SEP_W=0 makes SepLo == SepHi, an empty range.
  localparam logic [HCNT_W-1:0] SepLo = HCNT_W'(H_ACTIVE / 2 - SEP_W / 2);
  localparam logic [HCNT_W-1:0] SepHi = HCNT_W'(H_ACTIVE / 2 + SEP_W / 2);

  logic              pix_en;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic              hs_raw, vs_raw, active;
  logic              latch_en, in_sep;

  logic [CODE_W-1:0] code_q, code_d;
  rgb444_t           rgb_q, rgb_d;
  logic              hsync_q, vsync_q;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HCNT_W   (HCNT_W),
    .VCNT_W   (VCNT_W)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw),
    .active (active)
  );

  // Latch on the last pixel of the frame so the whole next frame uses one code.
  assign latch_en   = pix_en && (hcnt == HLast) && (vcnt == VLast);
  assign frame_tick = latch_en;
  assign in_sep     = (hcnt >= SepLo) && (hcnt < SepHi);

  always_comb begin
    code_d = latch_en ? code : code_q;
    rgb_d  = '0;
    if (active && !in_sep) begin
      rgb_d = (hcnt < HHalf) ? code_q[TENS_LSB +: RGB_W] : code_q[ONES_LSB +: RGB_W];
    end
  end

  // Sync and colour share the same register stage, keeping them pixel-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      code_q <= code_d;
      if (pix_en) begin
        rgb_q   <= rgb_d;
        hsync_q <= hs_raw;
        vsync_q <= vs_raw;
      end
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = rgb_q[RED_LSB +: CH_W];
  assign green = rgb_q[GREEN_LSB +: CH_W];
  assign blue  = rgb_q[BLUE_LSB +: CH_W];

endmodule

// File: tb/tb_vga_color_split.sv
// Bench for vga_color_split on a shrunken 24x10 raster: a pixel scoreboard for the CLK_DIV=2
// instance, plus colour tables, timing measurements and reset sequences on both instances.
module tb_vga_color_split;

  localparam int HT    = 24;   // 16 + 2 + 3 + 3
  localparam int VT    = 10;   // 6 + 1 + 2 + 1
  localparam int FR    = HT * VT;
  localparam int DIV_A = 2;

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
  } pix_vec_t;

  typedef struct {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] code = 24'hF00_0FF;
  logic        hsync_a, vsync_a, ft_a, hsync_b, vsync_b, ft_b;
  logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;

  always #5 clk = ~clk;

  vga_color_split #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SEP_W(4)
  ) dut_a (
    .clk(clk), .rst(rst), .code(code), .hsync(hsync_a), .vsync(vsync_a),
    .red(red_a), .green(green_a), .blue(blue_a), .frame_tick(ft_a)
  );

  vga_color_split #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SEP_W(0)
  ) dut_b (
    .clk(clk), .rst(rst), .code(code), .hsync(hsync_b), .vsync(vsync_b),
    .red(red_b), .green(green_b), .blue(blue_b), .frame_tick(ft_b)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int unsigned edge_n = 0;
  int          cyc = 0;
  int          ft_cnt = 0;
  int          mk;
  logic [23:0] mdl_code = '0;
  exp_t        sb_q[$];
  exp_t        sb_e;
  int          t0, t1, t2, tmp, base, ft0, n_a, n_b;
  pix_vec_t    tbl_a[11];
  pix_vec_t    tbl_b[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: got timeout, required event", name);
  endtask

  // Expected outputs of the 16-wide raster with a 4-pixel separator at 6..9.
  function automatic exp_t model_pixel(input int h, input int v, input logic [23:0] c);
    exp_t e;
    e.hs  = !(h >= 18 && h < 21);
    e.vs  = !(v >= 7 && v < 9);
    e.rgb = 12'h000;
    if (h < 16 && v < 6 && !(h >= 6 && h < 10)) e.rgb = (h < 8) ? c[23:12] : c[11:0];
    return e;
  endfunction

  function automatic int shown_pixel(input bit is_b);
    if (is_b) return int'(edge_n) - 1;
    return int'(edge_n / 2) - 1;
  endfunction

  // Stimulus side: push the expected outputs for each pixel enable of dut_a.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      edge_n   = 0;
      mdl_code = '0;
    end else begin
      if (edge_n % DIV_A == DIV_A - 1) begin
        mk = int'(edge_n / DIV_A) % FR;
        sb_q.push_back(model_pixel(mk % HT, mk / HT, mdl_code));
        if (mk == FR - 1) mdl_code = code;
      end
      edge_n++;
    end
  end

  // Response side: pop and compare once the registered outputs have settled.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
    end else begin
      if (sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        check("pixel_a", {hsync_a, vsync_a, red_a, green_a, blue_a}, {sb_e.hs, sb_e.vs, sb_e.rgb});
      end
      check("frame_tick_a", ft_a, (edge_n % 2 == 1) && ((edge_n / 2) % FR == FR - 1));
      if (ft_a) ft_cnt++;
    end
  end

  task automatic wait_sig(input int which, input logic val, output int at);
    logic s;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      case (which)
        0:       s = hsync_a;
        1:       s = vsync_a;
        2:       s = ft_a;
        3:       s = hsync_b;
        default: s = ft_b;
      endcase
      if (s === val) begin
        at = cyc;
        return;
      end
    end
    at = -1;
    fail($sformatf("wait_sig_%0d", which));
  endtask

  task automatic wait_pixel(input bit is_b, input int target);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!rst && shown_pixel(is_b) == target) return;
    end
    fail("wait_pixel");
  endtask

  // Posedges from reset release until each instance first drives hsync low.
  task automatic first_hsync(output int na, output int nb);
    na = -1;
    nb = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (na < 0 && !hsync_a) na = i;
      if (nb < 0 && !hsync_b) nb = i;
      if (na >= 0 && nb >= 0) break;
    end
  endtask

  initial begin
    tbl_a[0]  = '{3, 2, 12'hF00};
    tbl_a[1]  = '{5, 2, 12'hF00};
    tbl_a[2]  = '{6, 2, 12'h000};
    tbl_a[3]  = '{7, 2, 12'h000};
    tbl_a[4]  = '{8, 2, 12'h000};
    tbl_a[5]  = '{9, 2, 12'h000};
    tbl_a[6]  = '{10, 2, 12'h0FF};
    tbl_a[7]  = '{12, 2, 12'h0FF};
    tbl_a[8]  = '{15, 2, 12'h0FF};
    tbl_a[9]  = '{20, 2, 12'h000};
    tbl_a[10] = '{3, 7, 12'h000};
    tbl_b[0]  = '{6, 2, 12'hFFF};
    tbl_b[1]  = '{7, 2, 12'hFFF};
    tbl_b[2]  = '{8, 2, 12'h000};
    tbl_b[3]  = '{9, 2, 12'h000};

    repeat (3) @(negedge clk);
    check("reset_hsync_a", hsync_a, 1);
    check("reset_vsync_a", vsync_a, 1);
    check("reset_rgb_a", {red_a, green_a, blue_a}, 0);
    check("reset_tick_a", ft_a, 0);
    check("reset_sync_b", {hsync_b, vsync_b}, 2'b11);
    check("reset_rgb_b", {red_b, green_b, blue_b}, 0);

    #2 rst = 1'b0;
    first_hsync(n_a, n_b);
    check("first_hsync_a", n_a, 38);
    check("first_hsync_b", n_b, 19);

    wait_sig(0, 1, tmp); wait_sig(0, 0, t0); wait_sig(0, 1, t1); wait_sig(0, 0, t2);
    check("hsync_low_clk_a", t1 - t0, 6);
    check("line_clk_a", t2 - t0, 48);
    wait_sig(1, 1, tmp); wait_sig(1, 0, t0); wait_sig(1, 1, t1); wait_sig(1, 0, t2);
    check("vsync_low_clk_a", t1 - t0, 96);
    check("frame_clk_a", t2 - t0, 480);
    wait_sig(3, 1, tmp); wait_sig(3, 0, t0); wait_sig(3, 1, t1); wait_sig(3, 0, t2);
    check("hsync_low_clk_b", t1 - t0, 3);
    check("line_clk_b", t2 - t0, 24);

    base = (shown_pixel(0) / FR + 1) * FR;
    foreach (tbl_a[i]) begin
      wait_pixel(0, base + tbl_a[i].v * HT + tbl_a[i].h);
      check($sformatf("colour_a[%0d]", i), {red_a, green_a, blue_a}, tbl_a[i].rgb);
    end

    // Mid-frame code change must not show until the following frame.
    base = (shown_pixel(0) / FR + 1) * FR;
    wait_pixel(0, base + 3 * HT);
    #2 code = 24'hFFF_000;
    ft0 = ft_cnt;
    wait_pixel(0, base + 4 * HT + 3);
    check("tear_left", {red_a, green_a, blue_a}, 12'hF00);
    wait_pixel(0, base + 4 * HT + 12);
    check("tear_right", {red_a, green_a, blue_a}, 12'h0FF);
    wait_pixel(0, base + FR + HT + 3);
    check("new_left", {red_a, green_a, blue_a}, 12'hFFF);
    check("ticks_per_frame", ft_cnt - ft0, 1);
    wait_pixel(0, base + FR + HT + 12);
    check("new_right", {red_a, green_a, blue_a}, 12'h000);

    wait_sig(2, 0, tmp); wait_sig(2, 1, t0); wait_sig(2, 0, tmp); wait_sig(2, 1, t1);
    check("tick_spacing_a", t1 - t0, 480);
    wait_sig(4, 0, tmp); wait_sig(4, 1, t0); wait_sig(4, 0, tmp); wait_sig(4, 1, t1);
    check("tick_spacing_b", t1 - t0, 240);

    base = (shown_pixel(1) / FR + 1) * FR;
    foreach (tbl_b[i]) begin
      wait_pixel(1, base + tbl_b[i].v * HT + tbl_b[i].h);
      check($sformatf("colour_b[%0d]", i), {red_b, green_b, blue_b}, tbl_b[i].rgb);
    end

    // Asynchronous reset while a lit pixel is on screen, then while hsync is low.
    base = (shown_pixel(0) / FR + 1) * FR;
    wait_pixel(0, base + 2 * HT + 3);
    check("lit_before_reset", {red_a, green_a, blue_a}, 12'hFFF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rgb_a", {red_a, green_a, blue_a}, 0);
    check("async_rst_vsync_a", vsync_a, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_sig(0, 0, tmp);
    #2 rst = 1'b1;
    #1;
    check("async_rst_hsync_a", hsync_a, 1);
    check("async_rst_tick_a", ft_a, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    first_hsync(n_a, n_b);
    check("rerun_first_hsync_a", n_a, 38);
    check("rerun_first_hsync_b", n_b, 19);
    wait_pixel(0, 2 * HT + 3);
    check("cleared_code", {red_a, green_a, blue_a}, 12'h000);
    wait_pixel(0, FR + 2 * HT + 3);
    check("relatched_code", {red_a, green_a, blue_a}, 12'hFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
